// File: rtl/dff_chain_loader_pkg.sv
// ============================================================================
// Module      : dff_chain_loader_pkg
// Description : State encodings and counter sizing helper shared by the
//               DFF chain loader and its bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dff_chain_loader_pkg;

    // Sequencer states; 2'd3 is unused and steers back to IDLE
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_UPDT  = 2'd2;

    // Counter width: max(1, clog2(width)) so a 1-bit chain still has a counter bit
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage : dff_chain_loader_pkg

`default_nettype wire

// File: rtl/chain_bit_counter.sv
// ============================================================================
// Module      : chain_bit_counter
// Description : Counts shifted bits for one chain load. Saturates at
//               WIDTH-1 and flags the final bit with 'last'.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chain_bit_counter
    import dff_chain_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          clr,
    input  logic                          inc,
    output logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic                          last
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on a new load, otherwise advance without passing WIDTH-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule : chain_bit_counter

`default_nettype wire

// File: rtl/dff_chain_loader.sv
// ============================================================================
// Module      : dff_chain_loader
// Description : Serially loads a parallel word into a WIDTH-cell DFF chain,
//               captures the bits leaving the chain tail, then strobes
//               UPDATE / RDBK_VALID for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_chain_loader
    import dff_chain_loader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    output logic             SHIFT_EN,
    output logic             SHIFT_D,
    input  logic             CHAIN_Q,
    output logic             UPDATE,
    output logic [WIDTH-1:0] RDBK_DATA,
    output logic             RDBK_VALID,
    output logic             BUSY
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rdbk_q, rdbk_d;
    logic [WIDTH-1:0] tail_bit;
    logic             accept;
    logic             shifting;
    logic             last;
    logic [CNT_W-1:0] cnt_unused;   // exposed by the counter for debug only

    assign accept   = (state_q == ST_IDLE) && LOAD_VALID;
    assign shifting = (state_q == ST_SHIFT);

    chain_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (accept),
        .inc  (shifting),
        .cnt  (cnt_unused),
        .last (last)
    );

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdbk_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdbk_q  <= rdbk_d;
        end
    end

    // Next-state: one pass IDLE -> SHIFT (WIDTH cycles) -> UPDT -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (LOAD_VALID) state_d = ST_SHIFT;
            ST_SHIFT: if (last)       state_d = ST_UPDT;
            ST_UPDT:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Shift registers: the tail bit enters rx at the end opposite to the one
    // tx leaves from, so readback lands in LOAD_DATA bit order
    always_comb begin
        tail_bit = '0;
        tail_bit[MSB_FIRST ? 0 : WIDTH-1] = CHAIN_Q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        rdbk_d = rdbk_q;
        if (accept) begin
            tx_d = LOAD_DATA;
        end else if (shifting) begin
            if (MSB_FIRST) begin
                tx_d = tx_q << 1;
                rx_d = (rx_q << 1) | tail_bit;
            end else begin
                tx_d = tx_q >> 1;
                rx_d = (rx_q >> 1) | tail_bit;
            end
            // Capture the finished readback on the edge that enters UPDT
            if (last) begin
                rdbk_d = rx_d;
            end
        end
    end

    // Outputs decoded from state and shift registers only
    always_comb begin
        LOAD_READY = (state_q == ST_IDLE);
        SHIFT_EN   = shifting;
        SHIFT_D    = shifting & (MSB_FIRST ? tx_q[WIDTH-1] : tx_q[0]);
        UPDATE     = (state_q == ST_UPDT);
        RDBK_VALID = (state_q == ST_UPDT);
        BUSY       = shifting || (state_q == ST_UPDT);
        RDBK_DATA  = rdbk_q;
    end

endmodule : dff_chain_loader

`default_nettype wire
